// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use interlock, branch flush and memory-wait freeze with watchdog.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module hazard_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned WAIT_CNT_W  = 8
`ifdef HAZARD_PERF_EN
  , parameter int unsigned PERF_W    = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] in_IFID_rs1,
  input  logic [4:0] in_IFID_rs2,
  input  logic       in_IFID_uses_rs1,
  input  logic       in_IFID_uses_rs2,
  input  logic [4:0] in_IDEX_rd,
  input  logic       in_IDEX_mem_read,
  input  logic       in_EX_branch_taken,
  input  logic       in_mem_req,
  input  logic       in_mem_ready,
  output logic       out_PC_stall,
  output logic       out_IFID_stall,
  output logic       out_IFID_flush,
  output logic       out_IDEX_stall,
  output logic       out_IDEX_flush,
  output logic       out_EXMEM_stall,
  output logic       out_MEMWB_flush,
  output logic       out_mem_timeout,
  output logic       out_state
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0] out_perf_load_use
  , output logic [PERF_W-1:0] out_perf_flush
  , output logic [PERF_W-1:0] out_perf_mem_wait
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic                  timeout_nxt;
  logic                  load_use;
  logic                  mem_stall;
  logic                  sel_branch;
  logic                  sel_load_use;

  // Load-use: EX holds a load whose destination is a register ID actually reads (x0 excluded).
  always_comb begin
    load_use = in_IDEX_mem_read && (in_IDEX_rd != 5'd0) &&
               ((in_IFID_uses_rs1 && (in_IFID_rs1 == in_IDEX_rd)) ||
                (in_IFID_uses_rs2 && (in_IFID_rs2 == in_IDEX_rd)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      wait_cnt        <= '0;
      out_mem_timeout <= 1'b0;
    end else begin
      state           <= state_nxt;
      wait_cnt        <= wait_cnt_nxt;
      out_mem_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    timeout_nxt     = out_mem_timeout;
    mem_stall       = 1'b0;
    sel_branch      = 1'b0;
    sel_load_use    = 1'b0;
    out_PC_stall    = 1'b0;
    out_IFID_stall  = 1'b0;
    out_IFID_flush  = 1'b0;
    out_IDEX_stall  = 1'b0;
    out_IDEX_flush  = 1'b0;
    out_EXMEM_stall = 1'b0;
    out_MEMWB_flush = 1'b0;
    out_state       = 1'b0;

    case (state)
      RUN: begin
        if (in_mem_req && !in_mem_ready) begin
          mem_stall    = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (in_mem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt != '1) begin
            wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    // Watchdog trips on the stall cycle that brings the count to the limit; sticky until reset.
    if (mem_stall && (wait_cnt_nxt == WAIT_CNT_W'(MEM_TIMEOUT))) begin
      timeout_nxt = 1'b1;
    end

    if (mem_stall) begin
      out_PC_stall    = 1'b1;
      out_IFID_stall  = 1'b1;
      out_IDEX_stall  = 1'b1;
      out_EXMEM_stall = 1'b1;
      out_MEMWB_flush = 1'b1;
    end else if (in_EX_branch_taken) begin
      sel_branch     = 1'b1;
      out_IFID_flush = 1'b1;
      out_IDEX_flush = 1'b1;
    end else if (load_use) begin
      sel_load_use   = 1'b1;
      out_PC_stall   = 1'b1;
      out_IFID_stall = 1'b1;
      out_IDEX_flush = 1'b1;
    end

    out_state = (state == MEM_WAIT);

    // Reset forces every control low immediately, independent of the clock.
    if (reset) begin
      mem_stall       = 1'b0;
      sel_branch      = 1'b0;
      sel_load_use    = 1'b0;
      out_PC_stall    = 1'b0;
      out_IFID_stall  = 1'b0;
      out_IFID_flush  = 1'b0;
      out_IDEX_stall  = 1'b0;
      out_IDEX_flush  = 1'b0;
      out_EXMEM_stall = 1'b0;
      out_MEMWB_flush = 1'b0;
      out_state       = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters, credited only to the condition that owns the outputs this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_perf_load_use <= '0;
      out_perf_flush    <= '0;
      out_perf_mem_wait <= '0;
    end else begin
      if (sel_load_use && (out_perf_load_use != '1)) begin
        out_perf_load_use <= out_perf_load_use + PERF_W'(1);
      end
      if (sel_branch && (out_perf_flush != '1)) begin
        out_perf_flush <= out_perf_flush + PERF_W'(1);
      end
      if (mem_stall && (out_perf_mem_wait != '1)) begin
        out_perf_mem_wait <= out_perf_mem_wait + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table, hand-built wait/timeout/reset
// sequences, and a randomized run against a cycle-level reference model.
module tb_hazard_control_unit;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, req, rdy;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_stall, memwb_flush, mem_timeout, state_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_fl, perf_mw;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.MEM_TIMEOUT(TO), .WAIT_CNT_W(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_IFID_rs1        (rs1),
    .in_IFID_rs2        (rs2),
    .in_IFID_uses_rs1   (u1),
    .in_IFID_uses_rs2   (u2),
    .in_IDEX_rd         (rd),
    .in_IDEX_mem_read   (mr),
    .in_EX_branch_taken (br),
    .in_mem_req         (req),
    .in_mem_ready       (rdy),
    .out_PC_stall       (pc_stall),
    .out_IFID_stall     (ifid_stall),
    .out_IFID_flush     (ifid_flush),
    .out_IDEX_stall     (idex_stall),
    .out_IDEX_flush     (idex_flush),
    .out_EXMEM_stall    (exmem_stall),
    .out_MEMWB_flush    (memwb_flush),
    .out_mem_timeout    (mem_timeout),
    .out_state          (state_o)
`ifdef HAZARD_PERF_EN
    , .out_perf_load_use (perf_lu)
    , .out_perf_flush    (perf_fl)
    , .out_perf_mem_wait (perf_mw)
`endif
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, req, rdy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [6:0] exp;
    string      name;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state: in a memory wait, consecutive stall cycles, sticky timeout.
  bit m_wait = 0;
  int m_cnt  = 0;
  bit m_to   = 0;

  function automatic stim_t mk(int a, int b, bit x1, bit x2, int d, bit l, bit t, bit q, bit y);
    stim_t s;
    s.rs1 = 5'(a); s.rs2 = 5'(b); s.u1 = x1; s.u2 = x2; s.rd = 5'(d);
    s.mr = l; s.br = t; s.req = q; s.rdy = y;
    return s;
  endfunction

  function automatic logic [8:0] dut_out();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
            exmem_stall, memwb_flush, mem_timeout, state_o};
  endfunction

  // Bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall memwb_flush timeout state
  function automatic logic [8:0] model_out(stim_t s);
    bit hit1, hit2, lu, ms;
    logic [6:0] c;
    hit1 = s.u1 && (s.rs1 == s.rd);
    hit2 = s.u2 && (s.rs2 == s.rd);
    lu   = s.mr && (s.rd != 0) && (hit1 || hit2);
    ms   = m_wait ? !s.rdy : (s.req && !s.rdy);
    if (ms)        c = 7'b1101011;
    else if (s.br) c = 7'b0010100;
    else if (lu)   c = 7'b1100100;
    else           c = 7'b0000000;
    return {c, m_to, m_wait};
  endfunction

  function automatic void model_edge(stim_t s);
    bit ms;
    ms = m_wait ? !s.rdy : (s.req && !s.rdy);
    if (ms) begin
      m_cnt++;
      if (m_cnt >= int'(TO)) m_to = 1;
    end else begin
      m_cnt = 0;
    end
    m_wait = ms;
  endfunction

  function automatic void model_reset();
    m_wait = 0; m_cnt = 0; m_to = 0;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    rs1 = s.rs1; rs2 = s.rs2; u1 = s.u1; u2 = s.u2; rd = s.rd;
    mr = s.mr; br = s.br; req = s.req; rdy = s.rdy;
  endtask

  // One clock: drive, sample at negedge vs model (and optional explicit 9-bit constant), advance.
  task automatic step(input stim_t s, input bit use_exp, input logic [8:0] exp_c, input string name);
    drive(s);
    @(negedge clk);
    check({name, "/model"}, dut_out(), model_out(s));
    if (use_exp) check(name, dut_out(), exp_c);
    model_edge(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    model_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t  tbl[9];
  stim_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{mk(5, 0, 1, 0, 5, 1, 0, 0, 0), 7'b1100100, "lu_rs1"};
    tbl[1] = '{mk(5, 0, 1, 0, 5, 0, 0, 0, 0), 7'b0000000, "lu_release"};
    tbl[2] = '{mk(0, 0, 1, 0, 0, 1, 0, 0, 0), 7'b0000000, "lu_x0"};
    tbl[3] = '{mk(3, 7, 1, 0, 7, 1, 0, 0, 0), 7'b0000000, "lu_rs2_unused"};
    tbl[4] = '{mk(3, 9, 1, 1, 9, 1, 0, 0, 0), 7'b1100100, "lu_rs2"};
    tbl[5] = '{mk(5, 0, 1, 0, 5, 1, 1, 0, 0), 7'b0010100, "branch_over_lu"};
    tbl[6] = '{mk(1, 2, 1, 1, 3, 0, 1, 0, 0), 7'b0010100, "branch"};
    tbl[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 7'b0000000, "req_ready"};
    tbl[8] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 1), 7'b0010100, "req_ready_branch"};

    reset = 1'b1;
    drive(mk(5, 0, 1, 0, 5, 1, 1, 1, 0));
    #3;
    check("reset_outputs", dut_out(), 9'b0);
    do_reset();

    foreach (tbl[i]) step(tbl[i].s, 1'b1, {tbl[i].exp, 2'b00}, tbl[i].name);

    // Memory wait with a branch pending throughout: branch only wins in the release cycle.
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b1, 9'b1101011_0_0, "mw_c0");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b1, 9'b1101011_0_1, "mw_c1");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b1, 9'b1101011_0_1, "mw_c2");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1), 1'b1, 9'b0010100_0_1, "mw_release");
    step(idle, 1'b1, 9'b0, "mw_after");

    // Watchdog: visible after the 4th stall cycle, sticky across release.
    for (int k = 0; k < 6; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1,
           {7'b1101011, (k >= 4) ? 1'b1 : 1'b0, (k == 0) ? 1'b0 : 1'b1},
           $sformatf("timeout_c%0d", k));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 9'b0000000_1_1, "timeout_release");
    step(idle, 1'b1, 9'b0000000_1_0, "timeout_sticky");

    // Asynchronous reset in the middle of a wait.
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, 9'b1101011_1_0, "rst_wait_c0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, 9'b1101011_1_1, "rst_wait_c1");
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_mid_wait", dut_out(), 9'b0);
    model_reset();
    #2;
    reset = 1'b0;
    step(idle, 1'b1, 9'b0, "post_reset_idle");

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      s.rs1 = 5'($urandom_range(3));
      s.rs2 = 5'($urandom_range(3));
      s.u1  = 1'($urandom_range(1));
      s.u2  = 1'($urandom_range(1));
      s.rd  = 5'($urandom_range(3));
      s.mr  = 1'($urandom_range(1));
      s.br  = ($urandom_range(4) == 0);
      s.req = ($urandom_range(2) == 0);
      s.rdy = 1'($urandom_range(1));
      step(s, 1'b0, 9'b0, $sformatf("rand%0d", n));
    end

`ifdef HAZARD_PERF_EN
    do_reset();
    step(mk(5, 0, 1, 0, 5, 1, 0, 0, 0), 1'b0, 9'b0, "perf_lu0");
    step(idle, 1'b0, 9'b0, "perf_idle0");
    step(mk(6, 0, 1, 0, 6, 1, 0, 0, 0), 1'b0, 9'b0, "perf_lu1");
    step(idle, 1'b0, 9'b0, "perf_idle1");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, 9'b0, "perf_br");
    for (int k = 0; k < 3; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 9'b0, "perf_wait");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0, 9'b0, "perf_release");
    check("perf_load_use", 9'(perf_lu), 9'd2);
    check("perf_flush", 9'(perf_fl), 9'd1);
    check("perf_mem_wait", 9'(perf_mw), 9'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
